pipelined_adder: RTL and testbench

- Parametrised, pipelined two-operand adder with carry-in, carry-out and signed-overflow flag.
- Operand width is split into STAGES equal chunks; one chunk is resolved per pipeline stage, with the carry registered between stages.
- Valid/ready streaming interface on input and output, with full backpressure.
- Serves as the wide-add building block for datapath accumulators and multiply-accumulate units.

---
 rtl/pipelined_adder_pkg.sv | 21 ++
 rtl/pipelined_adder_chunk.sv | 27 ++
 rtl/pipelined_adder.sv | 131 +++++++++++++
 tb/tb_pipelined_adder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder: chunk-width derivation, parameter
// legality check and the 1-bit full-adder cell used by chunk_adder.
package pipelined_adder_pkg;

    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

    function automatic bit params_legal(input int width, input int stages);
        if (stages < 1) begin
            return 1'b0;
        end
        return (width >= 2) && ((width % stages) == 0);
    endfunction

    // Returns {carry, sum} of x + y + ci.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/pipelined_adder_chunk.sv
// chunk_adder: CW-bit combinational ripple adder built from full-adder cells.
// c_msb is the carry into the top bit, needed for signed overflow detection.
module chunk_adder
    import pipelined_adder_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout,
    output logic          c_msb
);

    logic [CW:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CW; i++) begin : g_fa
        assign {c[i+1], s[i]} = full_add(a[i], b[i], c[i]);
    end

    assign cout  = c[CW];
    assign c_msb = c[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into STAGES chunks, one chunk per stage,
// valid/ready with full backpressure. Define PIPELINED_ADDER_SUB_EN to add a 'sub' port.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be >= 2 and divisible by STAGES, STAGES must be >= 1");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

`ifdef PIPELINED_ADDER_SUB_EN
    // a - b = a + ~b + 1; cin is ignored while subtracting.
    assign b_eff = sub ? ~b : b;
    assign c0    = sub | cin;
`else
    assign b_eff = b;
    assign c0    = cin;
`endif

    // Per-stage registers: operand skew, partial-sum deskew, chunk carry, valid.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ovf_q;

    logic [CW-1:0]    ca   [STAGES];
    logic [CW-1:0]    cb   [STAGES];
    logic             ci   [STAGES];
    logic [CW-1:0]    cs   [STAGES];
    logic             co   [STAGES];
    logic             cm   [STAGES];
    logic [WIDTH-1:0] s_nx [STAGES];

    always_comb begin
        ca[0] = a[CW-1:0];
        cb[0] = b_eff[CW-1:0];
        ci[0] = c0;
        for (int k = 1; k < STAGES; k++) begin
            ca[k] = a_q[k-1][k*CW +: CW];
            cb[k] = b_q[k-1][k*CW +: CW];
            ci[k] = c_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        chunk_adder #(
            .CW(CW)
        ) u_chunk (
            .a     (ca[k]),
            .b     (cb[k]),
            .cin   (ci[k]),
            .s     (cs[k]),
            .cout  (co[k]),
            .c_msb (cm[k])
        );
    end

    // Lower chunks ride along from the previous stage; chunk k is filled in here.
    always_comb begin
        s_nx[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            s_nx[k] = s_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            s_nx[k][k*CW +: CW] = cs[k];
        end
    end

    assign adv = !v_q[STAGES-1] || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            v_q[0] <= in_valid;
            a_q[0] <= a;
            b_q[0] <= b_eff;
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= s_nx[k];
                c_q[k] <= co[k];
            end
            ovf_q <= co[STAGES-1] ^ cm[STAGES-1];
        end
    end

    assign in_ready  = adv;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: scoreboard of expected results,
// directed carry/overflow cases, stream with backpressure, mid-stream reset and a width sweep.
module tb_pipelined_adder;

    localparam int W = 32;
    localparam int S = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
    logic [W-1:0]  a, b, sum;
`ifdef PIPELINED_ADDER_SUB_EN
    logic          sub;
`endif

    logic          sw_valid, sw_cin;
    logic [7:0]    sa8, sb8;
    logic [63:0]   sa64, sb64;
    logic          r1_ready, r1_valid, r1_cout, r1_ovf;
    logic [7:0]    r1_sum;
    logic          r8_ready, r8_valid, r8_cout, r8_ovf;
    logic [7:0]    r8_sum;
    logic          r64_ready, r64_valid, r64_cout, r64_ovf;
    logic [63:0]   r64_sum;

    typedef struct {
        logic [65:0] res;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    logic [65:0] q1[$];
    logic [65:0] q8[$];
    logic [65:0] q64[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) dut_8x1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r1_ready),
        .a(sa8), .b(sb8), .cin(sw_cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(r1_valid), .out_ready(1'b1), .sum(r1_sum), .cout(r1_cout), .ovf(r1_ovf)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(8)) dut_8x8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r8_ready),
        .a(sa8), .b(sb8), .cin(sw_cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(r8_valid), .out_ready(1'b1), .sum(r8_sum), .cout(r8_cout), .ovf(r8_ovf)
    );

    pipelined_adder #(.WIDTH(64), .STAGES(2)) dut_64x2 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r64_ready),
        .a(sa64), .b(sb64), .cin(sw_cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(r64_valid), .out_ready(1'b1), .sum(r64_sum), .cout(r64_cout), .ovf(r64_ovf)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer add; overflow from operand/result sign bits.
    function automatic logic [65:0] refmodel(input logic [63:0] x, input logic [63:0] y,
                                             input logic ci, input int w);
        logic [64:0] mask, full;
        logic [63:0] s;
        logic        co, ov;
        mask = (65'd1 << w) - 65'd1;
        full = ({1'b0, x} & mask) + ({1'b0, y} & mask) + {64'd0, ci};
        s    = full[63:0] & mask[63:0];
        co   = full[w];
        ov   = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
        return {ov, co, s};
    endfunction

    task automatic checkOutput(input string tag, input logic [65:0] got, input logic [65:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, push expectation if accepted.
    task automatic applyStimulus(input logic [31:0] na, input logic [31:0] nb, input logic ncin,
                                 input logic nsub, input logic nvalid, input logic nready,
                                 input bit lat, output bit acc);
        exp_t        e;
        logic [31:0] bb;
        logic        cc;
        @(negedge clk);
        a         = na;
        b         = nb;
        cin       = ncin;
        in_valid  = nvalid;
        out_ready = nready;
`ifdef PIPELINED_ADDER_SUB_EN
        sub       = nsub;
`endif
        #1;
        acc = nvalid && in_ready;
        if (nvalid && !nready && out_valid)
            checkOutput("in_ready_stall", 66'(in_ready), 66'd0);
        if (acc) begin
            bb    = nsub ? ~nb : nb;
            cc    = nsub ? 1'b1 : ncin;
            e.res = refmodel({32'd0, na}, {32'd0, bb}, cc, W);
            e.cyc = cyc;
            e.lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic waitResult(input string tag);
        bit acc;
        int n = 0;
        do begin
            applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
            #1;
            n++;
        end while (!out_valid && n < 20);
        if (!out_valid) checkOutput({tag, "_timeout"}, 66'd0, 66'd1);
    endtask

    task automatic runStream(input int n, input int stall_at);
        int          i = 0;
        int          k = 0;
        logic [31:0] ra, rb;
        logic        rc;
        bit          acc, rdy;
        ra = $urandom;
        rb = $urandom;
        rc = 1'($urandom_range(1, 0));
        while (i < n && k < n + 100) begin
            rdy = !(stall_at >= 0 && k >= stall_at && k < stall_at + 5);
            applyStimulus(ra, rb, rc, 1'b0, 1'b1, rdy, stall_at < 0, acc);
            if (acc) begin
                i++;
                ra = $urandom;
                rb = $urandom;
                rc = 1'($urandom_range(1, 0));
            end
            k++;
        end
        if (i < n) checkOutput("stream_stuck", 66'(i), 66'(n));
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
            n++;
        end
        applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        checkOutput("drain_empty", 66'(sb.size()), 66'd0);
    endtask

    // Main DUT monitor: compare on every output transfer, check hold while stalled.
    exp_t        mon_e;
    logic [65:0] held, cur;
    bit          held_v = 1'b0;
    always @(negedge clk) begin
        #2;
        cur = {ovf, cout, 32'd0, sum};
        if (rst_n && out_valid) begin
            if (out_ready) begin
                held_v = 1'b0;
                if (sb.size() == 0) begin
                    checkOutput("spurious_out", 66'd1, 66'd0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("result", cur, mon_e.res);
                    if (mon_e.lat) checkOutput("latency", 66'(cyc - mon_e.cyc), 66'(S));
                end
            end else begin
                if (held_v) checkOutput("hold_stable", cur, held);
                held   = cur;
                held_v = 1'b1;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (r1_valid) begin
                if (q1.size() == 0) checkOutput("sw_8x1_spurious", 66'd1, 66'd0);
                else checkOutput("sw_8x1", {r1_ovf, r1_cout, 56'd0, r1_sum}, q1.pop_front());
            end
            if (r8_valid) begin
                if (q8.size() == 0) checkOutput("sw_8x8_spurious", 66'd1, 66'd0);
                else checkOutput("sw_8x8", {r8_ovf, r8_cout, 56'd0, r8_sum}, q8.pop_front());
            end
            if (r64_valid) begin
                if (q64.size() == 0) checkOutput("sw_64x2_spurious", 66'd1, 66'd0);
                else checkOutput("sw_64x2", {r64_ovf, r64_cout, r64_sum}, q64.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
`ifdef PIPELINED_ADDER_SUB_EN
        sub       = 1'b0;
`endif
        sw_valid  = 1'b0;
        sw_cin    = 1'b0;
        sa8       = '0;
        sb8       = '0;
        sa64      = '0;
        sb64      = '0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_out_valid", 66'(out_valid), 66'd0);
        checkOutput("rst_outputs", {ovf, cout, 32'd0, sum}, 66'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", 66'(in_ready), 66'd1);

        // Carry ripples through all four chunks.
        applyStimulus(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, acc);
        waitResult("ripple");
        checkOutput("ripple_out", {ovf, cout, 32'd0, sum}, {1'b0, 1'b1, 64'd0});

        applyStimulus(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, acc);
        waitResult("ovf_pos");
        checkOutput("ovf_pos_out", {ovf, cout, 32'd0, sum}, {1'b1, 1'b0, 64'h8000_0000});

        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, acc);
        waitResult("ovf_neg");
        checkOutput("ovf_neg_out", {ovf, cout, 32'd0, sum}, {1'b1, 1'b1, 64'd0});

`ifdef PIPELINED_ADDER_SUB_EN
        applyStimulus(32'd5, 32'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, acc);
        waitResult("sub");
        checkOutput("sub_out", {ovf, cout, 32'd0, sum}, {1'b0, 1'b0, 64'hFFFF_FFFE});
`endif

        runStream(100, -1);
        drain();

        runStream(30, 10);
        drain();

        // Three results in flight, then a one-cycle reset discards them.
        for (int i = 0; i < 3; i++)
            applyStimulus($urandom, $urandom, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, acc);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_valid", 66'(out_valid), 66'd0);
        repeat (6) applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, acc);
        waitResult("post_rst");
        checkOutput("post_rst_out", {ovf, cout, 32'd0, sum}, {1'b0, 1'b0, 64'h2345_678A});
        drain();

        // Width/stage sweep on the side instances.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            sa8      = 8'($urandom);
            sb8      = 8'($urandom);
            sa64     = {$urandom, $urandom};
            sb64     = {$urandom, $urandom};
            sw_cin   = 1'($urandom_range(1, 0));
            sw_valid = 1'b1;
            #1;
            if (r1_ready)  q1.push_back(refmodel({56'd0, sa8}, {56'd0, sb8}, sw_cin, 8));
            if (r8_ready)  q8.push_back(refmodel({56'd0, sa8}, {56'd0, sb8}, sw_cin, 8));
            if (r64_ready) q64.push_back(refmodel(sa64, sb64, sw_cin, 64));
        end
        @(negedge clk);
        sw_valid = 1'b0;
        repeat (12) @(negedge clk);
        #3;
        checkOutput("sw_8x1_drained", 66'(q1.size()), 66'd0);
        checkOutput("sw_8x8_drained", 66'(q8.size()), 66'd0);
        checkOutput("sw_64x2_drained", 66'(q64.size()), 66'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
